// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared definitions for the seven-segment scan controller:
//   - seg7_t          : 8-bit segment pattern, bit 7 = dp, bits 6:0 = {g,f,e,d,c,b,a}
//   - SEG_*_BIT       : bit positions inside seg7_t
//   - SEG7_HEX_TABLE  : active-high {g..a} patterns for hex digits 0..F
//   - SEG7_OFF        : all segments dark (active-high sense)
package seg7_pkg;

  typedef logic [7:0] seg7_t;

  localparam int SEG_A_BIT  = 0;
  localparam int SEG_B_BIT  = 1;
  localparam int SEG_C_BIT  = 2;
  localparam int SEG_D_BIT  = 3;
  localparam int SEG_E_BIT  = 4;
  localparam int SEG_F_BIT  = 5;
  localparam int SEG_G_BIT  = 6;
  localparam int SEG_DP_BIT = 7;

  // Entry n holds the pattern for hex digit n (index 15 is listed first).
  localparam logic [15:0][6:0] SEG7_HEX_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  localparam seg7_t SEG7_OFF = 8'h00;

endpackage

// File: rtl/seg7_scan_ctrl_decode.sv
// seg7_decode
// Combinational nibble -> segment pattern, active-high (polarity is applied
// by the parent).
//   nibble   in  4  hex digit to show
//   dp       in  1  decimal point request
//   blank    in  1  force the whole digit dark, dp included
//   suppress in  1  hide the digit segments but keep the dp (leading-zero case)
//   seg      out 8  seg7_t pattern, 1 = segment lit
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       blank,
  input  logic       suppress,
  output seg7_t      seg
);

  always_comb begin
    seg = SEG7_OFF;
    if (!blank) begin
      seg[SEG_DP_BIT] = dp;
      if (!suppress) begin
        seg[SEG_G_BIT:SEG_A_BIT] = SEG7_HEX_TABLE[nibble];
      end
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
// Time-multiplexed seven-segment display controller with double-buffered
// display contents (loads become visible only at frame boundaries).
//
// Parameters:
//   DIGITS      number of multiplexed digits (1..16)
//   DIV         clock cycles per digit slot (>= 2)
//   ACTIVE_LOW  1: SEG/AN asserted low, 0: asserted high
// Ports:
//   clk    in   1          system clock
//   RST    in   1          asynchronous active-high reset
//   load   in   1          capture value/dp/blank into the pending buffer
//   value  in   4*DIGITS   hex nibbles, nibble i drives digit i (digit 0 rightmost)
//   dp     in   DIGITS     decimal point per digit
//   blank  in   DIGITS     force digit dark, including its dp
//   SEG    out  8          {dp,g,f,e,d,c,b,a}, registered
//   AN     out  DIGITS     one-hot digit enable, registered
//   frame  out  1          one-cycle pulse at each full-scan wrap, registered
// Build option:
//   SEG7_LZS_EN  when defined, leading zeros (digit >= 1) are suppressed;
//                a suppressed digit still shows its dp.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DIGITS     = 8,
  parameter int DIV        = 100000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank,
  output logic [7:0]            SEG,
  output logic [DIGITS-1:0]     AN,
  output logic                  frame
);

  localparam int DIV_W = $clog2(DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic POL = (ACTIVE_LOW != 0);
  localparam logic [7:0]        SEG_IDLE = POL ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] AN_IDLE  = {DIGITS{POL}};

  // Scan position
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  // Pending (written by load) and active (displayed) buffers
  logic [4*DIGITS-1:0] pend_val_q, pend_val_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic [DIGITS-1:0]   pend_blank_q, pend_blank_d;
  logic                pend_v_q, pend_v_d;
  logic [4*DIGITS-1:0] act_val_q, act_val_d;
  logic [DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [DIGITS-1:0]   act_blank_q, act_blank_d;

  // Registered outputs
  logic [7:0]        seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic              frame_q, frame_d;

  logic              frame_now;
  logic [DIGITS-1:0] an_raw;
  logic [DIGITS-1:0] supp_vec;
  logic [3:0]        act_nib [DIGITS];
  seg7_t             seg_hi;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
    assign act_nib[gi] = act_val_q[4*gi +: 4];
  end

`ifdef SEG7_LZS_EN
  // Digit gi >= 1 is a leading zero when it and every digit above it are 0.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lzs
    if (gi == 0) begin : g_lsd
      assign supp_vec[gi] = 1'b0;
    end else begin : g_hi
      assign supp_vec[gi] = (act_val_q[4*DIGITS-1:4*gi] == '0);
    end
  end
`else
  assign supp_vec = '0;
`endif

  seg7_decode u_decode (
    .nibble   (act_nib[idx_q]),
    .dp       (act_dp_q[idx_q]),
    .blank    (act_blank_q[idx_q]),
    .suppress (supp_vec[idx_q]),
    .seg      (seg_hi)
  );

  assign frame_now = (div_cnt_q == DIV_LAST) && (idx_q == IDX_LAST);

  always_comb begin
    div_cnt_d    = div_cnt_q + 1'b1;
    idx_d        = idx_q;
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    pend_v_d     = pend_v_q;
    act_val_d    = act_val_q;
    act_dp_d     = act_dp_q;
    act_blank_d  = act_blank_q;
    an_raw       = '0;

    if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = '0;
      idx_d     = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    // Frame swap reads the old pending contents, so a load on the same
    // edge lands in pending and waits for the next frame.
    if (frame_now && pend_v_q) begin
      act_val_d   = pend_val_q;
      act_dp_d    = pend_dp_q;
      act_blank_d = pend_blank_q;
      pend_v_d    = 1'b0;
    end
    if (load) begin
      pend_val_d   = value;
      pend_dp_d    = dp;
      pend_blank_d = blank;
      pend_v_d     = 1'b1;
    end

    // First cycle of each slot keeps every anode off (anti-ghosting).
    if (div_cnt_q != '0) begin
      an_raw[idx_q] = 1'b1;
    end

    seg_d   = POL ? ~seg_hi : seg_hi;
    an_d    = POL ? ~an_raw : an_raw;
    frame_d = frame_now;
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      div_cnt_q    <= '0;
      idx_q        <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      pend_v_q     <= 1'b0;
      act_val_q    <= '0;
      act_dp_q     <= '0;
      act_blank_q  <= '1;
      seg_q        <= SEG_IDLE;
      an_q         <= AN_IDLE;
      frame_q      <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      idx_q        <= idx_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      pend_v_q     <= pend_v_d;
      act_val_q    <= act_val_d;
      act_dp_q     <= act_dp_d;
      act_blank_q  <= act_blank_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_q      <= frame_d;
    end
  end

  assign SEG   = seg_q;
  assign AN    = an_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl
// Bench for seg7_scan_ctrl with DIGITS=4, DIV=4, ACTIVE_LOW=1. A scan-position
// model (one step counter, position = steps mod 16) predicts SEG/AN/frame on
// every cycle; directed literal checks pin the model to hand-computed values.
// Honours SEG7_LZS_EN the same way the design does.
module tb_seg7_scan_ctrl;

  localparam int DIGITS = 4;
  localparam int DIV    = 4;
  localparam int FRAME  = DIGITS * DIV;

  localparam logic [6:0] HEX_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic        clk   = 1'b0;
  logic        rst   = 1'b0;
  logic        load  = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp    = '0;
  logic [3:0]  blank = '0;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame;

  int n_cmp = 0;
  int n_bad = 0;
  int cur_k = 0;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.DIGITS(DIGITS), .DIV(DIV), .ACTIVE_LOW(1)) dut (
    .clk   (clk),
    .RST   (rst),
    .load  (load),
    .value (value),
    .dp    (dp),
    .blank (blank),
    .SEG   (seg),
    .AN    (an),
    .frame (frame)
  );

  // ---------------- behavioural model ----------------
  int         m_steps;
  logic [3:0] m_pend_val [4];
  logic [3:0] m_act_val  [4];
  logic [3:0] m_pend_dp, m_pend_blank, m_act_dp, m_act_blank;
  bit         m_pend_v;
  logic [7:0] exp_seg;
  logic [3:0] exp_an;
  logic       exp_frame;

  function automatic logic [7:0] model_seg(int d);
    logic [6:0] segs;
    bit         sup;
    sup = 1'b0;
`ifdef SEG7_LZS_EN
    if (d > 0) begin
      sup = 1'b1;
      for (int j = d; j < 4; j++) if (m_act_val[j] != 4'h0) sup = 1'b0;
    end
`endif
    if (m_act_blank[d]) return 8'hFF;
    segs = sup ? 7'h00 : HEX_TAB[m_act_val[d]];
    return ~{m_act_dp[d], segs};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_steps      = 0;
      m_pend_v     = 1'b0;
      m_pend_dp    = '0;
      m_pend_blank = '0;
      m_act_dp     = '0;
      m_act_blank  = 4'hF;
      for (int j = 0; j < 4; j++) begin
        m_pend_val[j] = '0;
        m_act_val[j]  = '0;
      end
      exp_seg   = 8'hFF;
      exp_an    = 4'hF;
      exp_frame = 1'b0;
    end else begin
      int pos, d;
      pos       = m_steps % FRAME;
      d         = pos / DIV;
      exp_seg   = model_seg(d);
      exp_an    = (pos % DIV == 0) ? 4'hF : ~(4'b0001 << d);
      exp_frame = (pos == FRAME - 1);
      if (pos == FRAME - 1 && m_pend_v) begin
        for (int j = 0; j < 4; j++) m_act_val[j] = m_pend_val[j];
        m_act_dp    = m_pend_dp;
        m_act_blank = m_pend_blank;
        m_pend_v    = 1'b0;
      end
      if (load) begin
        for (int j = 0; j < 4; j++) m_pend_val[j] = value[4*j +: 4];
        m_pend_dp    = dp;
        m_pend_blank = blank;
        m_pend_v     = 1'b1;
      end
      m_steps++;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    n_cmp++;
    if (seg !== exp_seg || an !== exp_an || frame !== exp_frame) begin
      n_bad++;
      $display("FAIL model t=%0t SEG=%h req %h AN=%b req %b frame=%b req %b",
               $time, seg, exp_seg, an, exp_an, frame, exp_frame);
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s t=%0t got %h required %h", name, $time, act, req);
    end
  endtask

  task automatic goto_k(input int target);
    while (cur_k < target) begin
      @(negedge clk);
      cur_k++;
    end
  endtask

  task automatic wait_frame();
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      if (frame === 1'b1) begin
        cur_k = 0;
        return;
      end
    end
    n_cmp++;
    n_bad++;
    $display("FAIL wait_frame t=%0t got no frame pulse required one within %0d cycles",
             $time, 3 * FRAME);
  endtask

  task automatic show_load();
    $display("load t=%0t value=%h dp=%b blank=%b", $time, value, dp, blank);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t simulation did not finish", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    logic [15:0] v16;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_seg", seg, 8'hFF);
    check("reset_an", an, 4'hF);
    check("reset_frame", frame, 1'b0);

    // Release and load 12AF on the first edge.
    rst = 1'b0; load = 1'b1; value = 16'h12AF; dp = 4'h0; blank = 4'h0;
    show_load();
    lat = 0;
    for (int i = 1; i <= 3 * FRAME; i++) begin
      @(negedge clk);
      if (i == 1) load = 1'b0;
      if (i == FRAME - 1) check("dark_before_frame", seg, 8'hFF);
      if (frame === 1'b1) begin lat = i; break; end
    end
    check("first_frame_latency", lat, FRAME);

    cur_k = 0;
    goto_k(1);
    check("dead_an", an, 4'hF);
    check("dead_seg", seg, 8'h8E);
    goto_k(2);
    check("d0_an", an, 4'b1110);
    check("d0_seg_F", seg, 8'h8E);
    goto_k(14);
    check("d3_an", an, 4'b0111);
    check("d3_seg_1", seg, 8'hF9);

    // Asynchronous reset in the middle of a clock phase.
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async_rst_seg", seg, 8'hFF);
    check("async_rst_an", an, 4'hF);
    check("async_rst_frame", frame, 1'b0);

    // Release, load 1111, then load 2222 on the frame edge itself.
    @(negedge clk);
    rst = 1'b0; load = 1'b1; value = 16'h1111;
    show_load();
    lat = 0;
    for (int i = 1; i <= 3 * FRAME; i++) begin
      @(negedge clk);
      if (i == 1) load = 1'b0;
      if (i == FRAME - 1) begin
        load = 1'b1; value = 16'h2222;
        show_load();
      end
      if (frame === 1'b1) begin lat = i; break; end
    end
    load = 1'b0;
    check("post_rst_frame_latency", lat, FRAME);
    cur_k = 0;
    goto_k(2);
    check("ones_frame", seg, 8'hF9);
    goto_k(FRAME);
    check("frame_period", frame, 1'b1);
    goto_k(FRAME + 2);
    check("twos_frame", seg, 8'hA4);
    check("twos_an", an, 4'b1110);

    // Leading-zero pattern.
    load = 1'b1; value = 16'h0030; dp = 4'b0100; blank = 4'h0;
    show_load();
    goto_k(FRAME + 3);
    load = 1'b0;
    wait_frame();
    goto_k(2);
    check("lz_d0", seg, 8'hC0);
    goto_k(6);
    check("lz_d1", seg, 8'hB0);
    goto_k(10);
    check("lz_d2_an", an, 4'b1011);
`ifdef SEG7_LZS_EN
    check("lz_d2", seg, 8'h7F);
    goto_k(14);
    check("lz_d3", seg, 8'hFF);
`else
    check("lz_d2", seg, 8'h40);
    goto_k(14);
    check("lz_d3", seg, 8'hC0);
`endif

    // Blanked digit 0 with dp set: dark but still scanned.
    load = 1'b1; value = 16'h5678; dp = 4'b0001; blank = 4'b0001;
    show_load();
    goto_k(15);
    load = 1'b0;
    wait_frame();
    goto_k(2);
    check("blank_d0_seg", seg, 8'hFF);
    check("blank_d0_an", an, 4'b1110);
    goto_k(6);
    check("blank_d1_seg", seg, 8'hF8);

    // Randomised traffic, occasional asynchronous reset.
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      load = ($urandom_range(0, 15) == 0);
      if (load) begin
        v16   = 16'($urandom);
        v16   = v16 >> (4 * $urandom_range(0, 4));
        value = v16;
        dp    = 4'($urandom);
        blank = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
        show_load();
      end
      if ($urandom_range(0, 499) == 0) begin
        #2 rst = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;
      end
    end
    load = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
